// File: rtl/alu_ctrl_mc.sv
// ALU controller: registered ALUOp/funct decode plus an iterative-multiply sequencer.
// Latency: 1 cycle, request edge to ALUCtrl_o/ctrl_valid_o; a multiply keeps busy_o high for MULT_CYCLES cycles, then pulses done_o.
// Backpressure: busy_o is high while a multiply runs; requests seen then are dropped, so upstream must hold valid_i.
//
// Optional feature macro: ALU_CTRL_MULT_EN.
//   Defined:   funct 0x18 starts a multiply, with the MULT state and the step counter.
//   Undefined: funct 0x18 is illegal, busy_o/step_o/done_o are tied low and flush_i is ignored.
//
// Ports:
//   clk_i, rst_i         clock (rising edge); asynchronous active-low reset
//   valid_i              decode request valid
//   funct_i, ALUOp_i     R-type funct field; ALU op class from main control
//   flush_i              abort an in-flight multiply
//   ALUCtrl_o            registered ALU operation code (holds between requests)
//   ctrl_valid_o         one-cycle pulse: ALUCtrl_o was just updated
//   illegal_o            one-cycle pulse, with ctrl_valid_o, for an undecodable request
//   busy_o, step_o       high while the multiplier iterates
//   done_o               one-cycle pulse: multiply complete
module alu_ctrl_mc #(
  parameter int FUNCT_W     = 6,
  parameter int ALUOP_W     = 3,
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               flush_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               ctrl_valid_o,
  output logic               illegal_o,
  output logic               busy_o,
  output logic               step_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  // ALU operation codes
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_LUI  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_ORI  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_BEQ  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OP_BNE  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(11);
`ifdef ALU_CTRL_MULT_EN
  localparam logic [CTRL_W-1:0] OP_MULT = CTRL_W'(12);
`endif
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(13);

  // ALUOp classes
  localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] AOP_BEQ   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] AOP_RTYPE = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] AOP_BNE   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] AOP_ORI   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] AOP_LUI   = ALUOP_W'(3'b101);

  // R-type funct values
  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'h22);
  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] FN_NOR  = FUNCT_W'(6'h27);
  localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(6'h2a);
  localparam logic [FUNCT_W-1:0] FN_SLTU = FUNCT_W'(6'h2b);
  localparam logic [FUNCT_W-1:0] FN_SLL  = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] FN_SRL  = FUNCT_W'(6'h02);
`ifdef ALU_CTRL_MULT_EN
  localparam logic [FUNCT_W-1:0] FN_MULT = FUNCT_W'(6'h18);
`endif

  // ------------------------------------------------------------------
  // Combinational decode of the current request
  // ------------------------------------------------------------------
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_mult;
  logic              accept;

  always_comb begin
    dec_ctrl    = OP_ADD;
    dec_illegal = 1'b0;
    dec_mult    = 1'b0;
    case (ALUOp_i)
      AOP_ADD: dec_ctrl = OP_ADD;
      AOP_BEQ: dec_ctrl = OP_BEQ;
      AOP_BNE: dec_ctrl = OP_BNE;
      AOP_ORI: dec_ctrl = OP_ORI;
      AOP_LUI: dec_ctrl = OP_LUI;
      AOP_RTYPE: begin
        case (funct_i)
          FN_ADD:  dec_ctrl = OP_ADD;
          FN_SUB:  dec_ctrl = OP_SUB;
          FN_AND:  dec_ctrl = OP_AND;
          FN_OR:   dec_ctrl = OP_OR;
          FN_NOR:  dec_ctrl = OP_NOR;
          FN_SLT:  dec_ctrl = OP_SLT;
          FN_SLTU: dec_ctrl = OP_SLTU;
          FN_SLL:  dec_ctrl = OP_SLL;
          FN_SRL:  dec_ctrl = OP_SRL;
`ifdef ALU_CTRL_MULT_EN
          FN_MULT: begin
            dec_ctrl = OP_MULT;
            dec_mult = 1'b1;
          end
`endif
          // Unlisted funct: report illegal, drive a harmless add.
          default: begin
            dec_ctrl    = OP_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      // ALUOp 110/111 are unassigned classes.
      default: begin
        dec_ctrl    = OP_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

`ifdef ALU_CTRL_MULT_EN
  // ------------------------------------------------------------------
  // Multiply sequencer
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // DONE accepts requests too, which gives zero-bubble back-to-back multiplies.
  assign accept = valid_i && (state_q != S_MULT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept && dec_mult) begin
          state_d = S_MULT;
          // Loading N-1 and leaving at 0 gives exactly N cycles in MULT.
          cnt_d   = CNT_W'(MULT_CYCLES - 1);
        end
      end
      S_MULT: begin
        if (flush_i) begin
          // Abort: skip DONE so no completion is reported.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are decodes of the registered state.
  assign busy_o = (state_q == S_MULT);
  assign step_o = (state_q == S_MULT);
  assign done_o = (state_q == S_DONE);
`else
  // Without the multiplier every request is accepted immediately.
  assign accept = valid_i;
  assign busy_o = 1'b0;
  assign step_o = 1'b0;
  assign done_o = 1'b0;

  // flush_i has nothing to abort; dec_mult is never set.
  wire unused_cfg = &{1'b0, flush_i, dec_mult, CNT_W'(MULT_CYCLES)};
`endif

  // ------------------------------------------------------------------
  // Registered decode outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALUCtrl_o    <= OP_ADD;
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      ctrl_valid_o <= accept;
      illegal_o    <= accept && dec_illegal;
      // ALUCtrl_o holds its value when no request is accepted.
      if (accept) begin
        ALUCtrl_o <= dec_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
module tb_alu_ctrl_mc;

  localparam int MC = 4;
`ifdef ALU_CTRL_MULT_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic       clk_i;
  logic       rst_i;
  logic       valid_i;
  logic [5:0] funct_i;
  logic [2:0] ALUOp_i;
  logic       flush_i;
  logic [3:0] ALUCtrl_o;
  logic       ctrl_valid_o;
  logic       illegal_o;
  logic       busy_o;
  logic       step_o;
  logic       done_o;

  alu_ctrl_mc #(
    .FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4), .MULT_CYCLES(MC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i),
    .ALUOp_i(ALUOp_i), .flush_i(flush_i), .ALUCtrl_o(ALUCtrl_o),
    .ctrl_valid_o(ctrl_valid_o), .illegal_o(illegal_o), .busy_o(busy_o),
    .step_o(step_o), .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard monitor: one entry per accepted request, due one cycle later.
  always @(negedge clk_i) begin
    if (mon_en && rst_i) begin
      exp_t e;
      check_val("ctrl_valid", ctrl_valid_o, sb.size() != 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (ctrl_valid_o) begin
          check_val("alu_ctrl", ALUCtrl_o, e.ctrl);
          check_val("illegal", illegal_o, e.ill);
        end
      end else begin
        check_val("illegal_idle", illegal_o, 1'b0);
      end
    end
  end

  // Drives one cycle of inputs (from negedge+1), optionally pushes the expected
  // result, and returns at negedge+1 of the following cycle.
  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic fl, input logic push, input logic [3:0] ectrl,
                       input logic eill);
    valid_i = v;
    ALUOp_i = op;
    funct_i = fn;
    flush_i = fl;
    if (push) sb.push_back('{ctrl: ectrl, ill: eill});
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 6'h00, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic check_status(input string tag, input logic eb, input logic ed);
    check_val({tag, "_busy"}, busy_o, eb);
    check_val({tag, "_step"}, step_o, eb);
    check_val({tag, "_done"}, done_o, ed);
  endtask

  logic [5:0] sweep_fn [9];
  logic [3:0] sweep_op [9];
  logic [3:0] mult_code;

  initial begin
    sweep_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02};
    sweep_op = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd13, 4'd4, 4'd5, 4'd6, 4'd11};
    mult_code = MEN ? 4'd12 : 4'd0;

    rst_i = 1'b0; valid_i = 1'b0; funct_i = '0; ALUOp_i = '0; flush_i = 1'b0;

    // Reset state
    #12;
    check_val("rst_ctrl", ALUCtrl_o, 4'd0);
    check_val("rst_cvalid", ctrl_valid_o, 1'b0);
    check_val("rst_illegal", illegal_o, 1'b0);
    check_status("rst", 1'b0, 1'b0);
    @(negedge clk_i); #1;
    rst_i  = 1'b1;
    mon_en = 1'b1;
    idle();
    check_val("post_rst_ctrl", ALUCtrl_o, 4'd0);

    // R-type decode sweep, back to back
    for (int i = 0; i < 9; i++)
      drive(1'b1, 3'b010, sweep_fn[i], 1'b0, 1'b1, sweep_op[i], 1'b0);
    idle();
    check_val("hold_ctrl", ALUCtrl_o, 4'd11);

    // Non-R-type classes
    drive(1'b1, 3'b000, 6'h3f, 1'b0, 1'b1, 4'd0, 1'b0);
    drive(1'b1, 3'b001, 6'h00, 1'b0, 1'b1, 4'd9, 1'b0);
    drive(1'b1, 3'b011, 6'h00, 1'b0, 1'b1, 4'd10, 1'b0);
    drive(1'b1, 3'b100, 6'h00, 1'b0, 1'b1, 4'd8, 1'b0);
    drive(1'b1, 3'b101, 6'h00, 1'b0, 1'b1, 4'd7, 1'b0);

    // Illegal requests
    drive(1'b1, 3'b110, 6'h20, 1'b0, 1'b1, 4'd0, 1'b1);
    check_status("ill1", 1'b0, 1'b0);
    drive(1'b1, 3'b111, 6'h20, 1'b0, 1'b1, 4'd0, 1'b1);
    drive(1'b1, 3'b010, 6'h3f, 1'b0, 1'b1, 4'd0, 1'b1);
    check_status("ill3", 1'b0, 1'b0);
    idle();

    // Multiply: busy k+1..k+MC, done k+MC+1; add during busy dropped
    drive(1'b1, 3'b010, 6'h18, 1'b0, 1'b1, mult_code, !MEN);
    check_status("mul_c1", MEN, 1'b0);
    for (int c = 2; c <= MC; c++) begin
      if (c == 2) drive(1'b1, 3'b000, 6'h00, 1'b0, !MEN, 4'd0, 1'b0);
      else        idle();
      check_status("mul_cn", MEN, 1'b0);
      check_val("mul_hold", ALUCtrl_o, (MEN ? 4'd12 : 4'd0));
    end
    idle();
    check_status("mul_done", 1'b0, MEN);
    // Add issued in the done cycle is accepted (zero bubble)
    drive(1'b1, 3'b000, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    check_status("mul_after", 1'b0, 1'b0);
    idle();

    // Flush with a request in the 2nd MULT cycle
    drive(1'b1, 3'b010, 6'h18, 1'b0, 1'b1, mult_code, !MEN);
    idle();
    check_status("fl_c2", MEN, 1'b0);
    drive(1'b1, 3'b010, 6'h20, 1'b1, !MEN, 4'd0, 1'b0);
    check_status("fl_c3", 1'b0, 1'b0);
    for (int c = 0; c < MC + 2; c++) begin
      idle();
      check_status("fl_tail", 1'b0, 1'b0);
    end
    check_val("fl_hold", ALUCtrl_o, mult_code);

    // Asynchronous reset mid-multiply
    drive(1'b1, 3'b010, 6'h18, 1'b0, 1'b1, mult_code, !MEN);
    idle();
    check_status("ar_pre", MEN, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    check_val("ar_ctrl", ALUCtrl_o, 4'd0);
    check_val("ar_cvalid", ctrl_valid_o, 1'b0);
    check_status("ar_now", 1'b0, 1'b0);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    for (int c = 0; c < MC + 2; c++) begin
      idle();
      check_status("ar_tail", 1'b0, 1'b0);
    end
    check_val("ar_ctrl_rel", ALUCtrl_o, 4'd0);

    check_val("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
